keylock_controller_n: RTL and testbench
=======================================

# keylock_controller_n

Parametrised keypad lock controller: collects an N-digit code from the keypad decoder, compares it against an internally stored code, and toggles lock state or reprograms the code. It replaces the fixed-function controller with a design that has its own entry buffer and comparator, an attempt counter with lockout, an entry timeout, and configurable command keys. It sits between the keypad scanner (`rdy`/`keypress`) and the LED/indicator drivers.

## Interface
- `CODE_DIGITS`, default 4: code length in digits, 1..8.
- `RESET_CODE`, default 32'h0000_1234: code loaded at reset; low `4*CODE_DIGITS` bits are used.
- `KEY_ENTER`, default 4'hA: command key that submits an unlock/lock entry.
- `KEY_CANCEL`, default 4'hB: command key that aborts an entry.
- `KEY_PROG`, default 4'hC: command key that starts and advances reprogramming.
- `MAX_ATTEMPTS`, default 3: consecutive failures before lockout, 1..15.
- `BLINK_CYCLES`, default 4: duration of the OK and ERROR states.
- `LOCKOUT_CYCLES`, default 16: duration of the LOCKOUT state.
- `TIMEOUT_CYCLES`, default 32: idle cycles allowed between keys during entry.
- `clk` in 1: system clock, all logic on the rising edge.
- `resetN` in 1: asynchronous active-low reset.
- `rdy` in 1: one-cycle key strobe; every cycle with `rdy`=1 is one keypress.
- `keypress` in 4: key value, sampled when `rdy`=1; 0-9 are digits.
- `locked` out 1: current lock state.
- `ok_led` out 1: high in OK.
- `err_led` out 1: high in ERROR.
- `lockout` out 1: high in LOCKOUT.
- `prog_mode` out 1: high in PROG_OLD, PROG_NEW and PROG_CONFIRM.
- `entry_active` out 1: high in ENTRY and all PROG_* states.
- `digit_count` out clog2(CODE_DIGITS+1): number of digits buffered.
- `fail_count` out 4: number of consecutive failures.
- `timeout_pulse` out 1: one-cycle pulse when an entry times out.
- `code_changed` out 1: one-cycle pulse when a new code is committed.

## Operation
- States: IDLE, ENTRY, PROG_OLD, PROG_NEW, PROG_CONFIRM, OK, ERROR, LOCKOUT.
- Reset values: state IDLE, `locked`=0, stored code=RESET_CODE, buffer=0, `digit_count`=0, `fail_count`=0, all LED outputs and pulses 0.
- Key classes:
  - digit: `keypress` 0-9.
  - command: KEY_ENTER, KEY_CANCEL or KEY_PROG.
  - any other value is ignored in every state.
- Digit entry: the digit shifts into the low nibble of the buffer and `digit_count` increments.
  - If a digit arrives when `digit_count`==CODE_DIGITS, the `overflow` flag is set and the count holds.
  - An entry is valid only when `digit_count`==CODE_DIGITS and `overflow`=0.
- IDLE:
  - digit → ENTRY, with that digit captured.
  - KEY_PROG → PROG_OLD, buffer cleared.
  - KEY_ENTER and KEY_CANCEL are ignored.
- ENTRY:
  - KEY_ENTER with a valid entry that equals the stored code → OK; `locked` toggles; `fail_count` clears.
  - KEY_ENTER otherwise → FAIL.
  - KEY_PROG is ignored.
- PROG_OLD:
  - KEY_PROG with a valid entry that matches → PROG_NEW; buffer clears; `fail_count` clears.
  - KEY_PROG otherwise → FAIL.
- PROG_NEW:
  - KEY_PROG with a valid entry → buffer copied to `pending`; buffer clears; → PROG_CONFIRM.
  - KEY_PROG otherwise → ERROR, with no attempt penalty.
- PROG_CONFIRM:
  - KEY_PROG with a valid entry equal to `pending` → stored code←`pending`; `code_changed` pulses; → OK. `locked` is unchanged.
  - KEY_PROG otherwise → ERROR, no penalty; the stored code is unchanged.
- KEY_CANCEL in ENTRY or any PROG_* state → IDLE, no penalty.
- KEY_ENTER in a PROG_* state is ignored.
- FAIL (transition action, not a state):
  - `fail_count`+1; if the result equals MAX_ATTEMPTS → LOCKOUT, else → ERROR.
  - `fail_count` saturates at 15.
- OK and ERROR each last exactly BLINK_CYCLES cycles, then → IDLE.
- LOCKOUT lasts LOCKOUT_CYCLES cycles, then `fail_count` clears and → IDLE.
- All keys are ignored in OK, ERROR and LOCKOUT.
- Timeout:
  - The counter runs in ENTRY and the PROG_* states and reloads on every `rdy`.
  - After TIMEOUT_CYCLES cycles without `rdy` → IDLE, `timeout_pulse`=1, no penalty.
  - If `rdy` arrives on the expiry cycle, the key wins and no timeout occurs.
- Buffer, `digit_count` and `overflow` clear on every entry into IDLE. `pending` is discarded.

## Timing
- A key in cycle N is acted on at the rising edge ending N; the new state and outputs are visible in N+1.
- All outputs are registered; there are no combinational paths from input to output.
- `ok_led` and `err_led` are high for exactly BLINK_CYCLES consecutive cycles; `lockout` for exactly LOCKOUT_CYCLES.
- `timeout_pulse` and `code_changed` are high for exactly one cycle.
- `locked` updates in the same cycle that `ok_led` rises.
- `resetN` assertion mid-operation forces reset values immediately, including restoring RESET_CODE.

## Test plan
Parameters for all scenarios: CODE_DIGITS=4, RESET_CODE=0x1234, MAX_ATTEMPTS=3, BLINK_CYCLES=4, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=32.

- Keys 1,2,3,4,A → `locked`=1 and `ok_led` high for 4 cycles; repeating the sequence → `locked`=0.
- Three entries of 1,2,3,5,A → two ERROR blinks with `fail_count` 1 then 2, then `lockout` for 16 cycles with all keys ignored; `fail_count` is 0 after lockout.
- Keys 1,2,3,4,5,A (overflow) → ERROR and `fail_count`=1; 1,2,A (short entry) → ERROR and `fail_count`=2.
- Keys C,1,2,3,4,C,9,8,7,6,C,9,8,7,6,C → `code_changed` pulse and OK; then 9,8,7,6,A unlocks the toggle and 1,2,3,4,A fails.
- Keys C,1,2,3,4,C,5,5,5,5,C,5,5,5,6,C → ERROR with `fail_count`=0; 1,2,3,4,A still succeeds.
- Keys 1,2 then 32 idle cycles → `timeout_pulse` and IDLE with `digit_count`=0; in a separate run, `rdy` on the expiry cycle keeps ENTRY; `resetN` low mid-entry → all outputs return to reset values.

Source files
------------

// File: rtl/keylock_controller_n.sv
`default_nettype none
// ============================================================================
// Module   : keylock_controller_n
// Brief    : Keypad lock controller with stored code, attempt lockout,
//            entry timeout and in-field code reprogramming.
// Revision : 1.0 - initial release
// ============================================================================
module keylock_controller_n #(
    parameter int          CODE_DIGITS    = 4,
    parameter logic [31:0] RESET_CODE     = 32'h0000_1234,
    parameter logic [3:0]  KEY_ENTER      = 4'hA,
    parameter logic [3:0]  KEY_CANCEL     = 4'hB,
    parameter logic [3:0]  KEY_PROG       = 4'hC,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter int          BLINK_CYCLES   = 4,
    parameter int          LOCKOUT_CYCLES = 16,
    parameter int          TIMEOUT_CYCLES = 32
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             rdy,
    input  logic [3:0]                       keypress,
    output logic                             locked,
    output logic                             ok_led,
    output logic                             err_led,
    output logic                             lockout,
    output logic                             prog_mode,
    output logic                             entry_active,
    output logic [$clog2(CODE_DIGITS+1)-1:0] digit_count,
    output logic [3:0]                       fail_count,
    output logic                             timeout_pulse,
    output logic                             code_changed
);

    localparam int c_BW      = 4 * CODE_DIGITS;
    localparam int c_DCW     = $clog2(CODE_DIGITS + 1);
    localparam int c_DUR_MAX = (LOCKOUT_CYCLES > BLINK_CYCLES) ? LOCKOUT_CYCLES : BLINK_CYCLES;
    localparam int c_DURW    = $clog2(c_DUR_MAX + 1);
    localparam int c_TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_DCW-1:0]  c_FULL       = c_DCW'(CODE_DIGITS);
    localparam logic [c_DURW-1:0] c_BLINK_LOAD = c_DURW'(BLINK_CYCLES - 1);
    localparam logic [c_DURW-1:0] c_LOCK_LOAD  = c_DURW'(LOCKOUT_CYCLES - 1);
    localparam logic [c_TW-1:0]   c_TMO_LOAD   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]        c_MAX_FAIL   = 4'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ENTRY        = 3'd1,
        S_PROG_OLD     = 3'd2,
        S_PROG_NEW     = 3'd3,
        S_PROG_CONFIRM = 3'd4,
        S_OK           = 3'd5,
        S_ERROR        = 3'd6,
        S_LOCKOUT      = 3'd7
    } state_t;

    state_t            r_state, w_state_nxt, w_fail_state;
    logic              r_locked, w_locked_nxt;
    logic [c_BW-1:0]   r_code, w_code_nxt;
    logic [c_BW-1:0]   r_buf, w_buf_nxt, w_buf_shift;
    logic [c_BW-1:0]   r_pending, w_pending_nxt;
    logic [c_DCW-1:0]  r_dcnt, w_dcnt_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [3:0]        r_fail, w_fail_nxt, w_fail_inc;
    logic [c_DURW-1:0] r_dur, w_dur_nxt;
    logic [c_TW-1:0]   r_tmo, w_tmo_nxt;
    logic              w_tmo_pulse_nxt, w_code_chg_nxt;
    logic              r_ok_led, r_err_led, r_lockout, r_prog, r_entry;
    logic              r_tmo_pulse, r_code_chg;

    logic w_is_digit, w_is_enter, w_is_cancel, w_is_prog;
    logic w_in_entry, w_nxt_in_entry, w_valid, w_match_code;

    assign w_is_digit   = rdy && (keypress <= 4'd9);
    assign w_is_enter   = rdy && (keypress == KEY_ENTER);
    assign w_is_cancel  = rdy && (keypress == KEY_CANCEL);
    assign w_is_prog    = rdy && (keypress == KEY_PROG);
    assign w_in_entry   = (r_state == S_ENTRY) || (r_state == S_PROG_OLD) ||
                          (r_state == S_PROG_NEW) || (r_state == S_PROG_CONFIRM);
    assign w_nxt_in_entry = (w_state_nxt == S_ENTRY) || (w_state_nxt == S_PROG_OLD) ||
                            (w_state_nxt == S_PROG_NEW) || (w_state_nxt == S_PROG_CONFIRM);
    assign w_valid      = (r_dcnt == c_FULL) && !r_ovf;
    assign w_match_code = w_valid && (r_buf == r_code);
    assign w_fail_inc   = (r_fail == 4'hF) ? 4'hF : r_fail + 4'd1;
    assign w_fail_state = (w_fail_inc == c_MAX_FAIL) ? S_LOCKOUT : S_ERROR;

    generate
        if (CODE_DIGITS == 1) begin : g_shift_single
            assign w_buf_shift = keypress;
        end else begin : g_shift_multi
            assign w_buf_shift = {r_buf[c_BW-5:0], keypress};
        end
    endgenerate

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_locked    <= 1'b0;
            r_code      <= RESET_CODE[c_BW-1:0];
            r_buf       <= '0;
            r_pending   <= '0;
            r_dcnt      <= '0;
            r_ovf       <= 1'b0;
            r_fail      <= 4'd0;
            r_dur       <= '0;
            r_tmo       <= '0;
            r_ok_led    <= 1'b0;
            r_err_led   <= 1'b0;
            r_lockout   <= 1'b0;
            r_prog      <= 1'b0;
            r_entry     <= 1'b0;
            r_tmo_pulse <= 1'b0;
            r_code_chg  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_locked    <= w_locked_nxt;
            r_code      <= w_code_nxt;
            r_buf       <= w_buf_nxt;
            r_pending   <= w_pending_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_ovf       <= w_ovf_nxt;
            r_fail      <= w_fail_nxt;
            r_dur       <= w_dur_nxt;
            r_tmo       <= w_tmo_nxt;
            r_ok_led    <= (w_state_nxt == S_OK);
            r_err_led   <= (w_state_nxt == S_ERROR);
            r_lockout   <= (w_state_nxt == S_LOCKOUT);
            r_prog      <= w_nxt_in_entry && (w_state_nxt != S_ENTRY);
            r_entry     <= w_nxt_in_entry;
            r_tmo_pulse <= w_tmo_pulse_nxt;
            r_code_chg  <= w_code_chg_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_locked_nxt    = r_locked;
        w_code_nxt      = r_code;
        w_buf_nxt       = r_buf;
        w_pending_nxt   = r_pending;
        w_dcnt_nxt      = r_dcnt;
        w_ovf_nxt       = r_ovf;
        w_fail_nxt      = r_fail;
        w_dur_nxt       = r_dur;
        w_tmo_nxt       = rdy ? c_TMO_LOAD : ((r_tmo != '0) ? r_tmo - c_TW'(1) : r_tmo);
        w_tmo_pulse_nxt = 1'b0;
        w_code_chg_nxt  = 1'b0;

        // IDLE buffer is always clear, so a first digit shifts in like any other
        if (w_is_digit && ((r_state == S_IDLE) || w_in_entry)) begin
            w_buf_nxt = w_buf_shift;
            if (r_dcnt == c_FULL) w_ovf_nxt = 1'b1;
            else                  w_dcnt_nxt = r_dcnt + c_DCW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_is_digit)     w_state_nxt = S_ENTRY;
                else if (w_is_prog) w_state_nxt = S_PROG_OLD;
            end
            S_ENTRY: begin
                if (w_is_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_enter) begin
                    if (w_match_code) begin
                        w_state_nxt  = S_OK;
                        w_locked_nxt = !r_locked;
                        w_fail_nxt   = 4'd0;
                    end else begin
                        w_fail_nxt  = w_fail_inc;
                        w_state_nxt = w_fail_state;
                    end
                end
            end
            S_PROG_OLD: begin
                if (w_is_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_prog) begin
                    if (w_match_code) begin
                        w_state_nxt = S_PROG_NEW;
                        w_buf_nxt   = '0;
                        w_dcnt_nxt  = '0;
                        w_ovf_nxt   = 1'b0;
                        w_fail_nxt  = 4'd0;
                    end else begin
                        w_fail_nxt  = w_fail_inc;
                        w_state_nxt = w_fail_state;
                    end
                end
            end
            S_PROG_NEW: begin
                if (w_is_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_prog) begin
                    if (w_valid) begin
                        w_state_nxt   = S_PROG_CONFIRM;
                        w_pending_nxt = r_buf;
                        w_buf_nxt     = '0;
                        w_dcnt_nxt    = '0;
                        w_ovf_nxt     = 1'b0;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_PROG_CONFIRM: begin
                if (w_is_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (w_is_prog) begin
                    if (w_valid && (r_buf == r_pending)) begin
                        w_state_nxt    = S_OK;
                        w_code_nxt     = r_pending;
                        w_code_chg_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_OK, S_ERROR: begin
                if (r_dur == '0) w_state_nxt = S_IDLE;
                else             w_dur_nxt   = r_dur - c_DURW'(1);
            end
            S_LOCKOUT: begin
                if (r_dur == '0) begin
                    w_state_nxt = S_IDLE;
                    w_fail_nxt  = 4'd0;
                end else begin
                    w_dur_nxt = r_dur - c_DURW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Any key on the expiry cycle keeps the entry alive
        if (w_in_entry && !rdy && (r_tmo == '0)) begin
            w_state_nxt     = S_IDLE;
            w_tmo_pulse_nxt = 1'b1;
        end

        if (w_state_nxt != r_state) begin
            case (w_state_nxt)
                S_OK, S_ERROR: w_dur_nxt = c_BLINK_LOAD;
                S_LOCKOUT:     w_dur_nxt = c_LOCK_LOAD;
                default:       w_dur_nxt = r_dur;
            endcase
        end

        if (!((w_state_nxt == S_ENTRY) || (w_state_nxt == S_PROG_OLD) ||
              (w_state_nxt == S_PROG_NEW) || (w_state_nxt == S_PROG_CONFIRM))) begin
            w_buf_nxt     = '0;
            w_dcnt_nxt    = '0;
            w_ovf_nxt     = 1'b0;
            w_pending_nxt = '0;
        end
    end

    assign locked        = r_locked;
    assign ok_led        = r_ok_led;
    assign err_led       = r_err_led;
    assign lockout       = r_lockout;
    assign prog_mode     = r_prog;
    assign entry_active  = r_entry;
    assign digit_count   = r_dcnt;
    assign fail_count    = r_fail;
    assign timeout_pulse = r_tmo_pulse;
    assign code_changed  = r_code_chg;

endmodule
`default_nettype wire

// File: tb/tb_keylock_controller_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_keylock_controller_n
// Brief    : Directed plus random key stimulus against a queue-based lock model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keylock_controller_n;

    localparam int          CODE_DIGITS    = 4;
    localparam logic [31:0] RESET_CODE     = 32'h0000_1234;
    localparam logic [3:0]  KEY_ENTER      = 4'hA;
    localparam logic [3:0]  KEY_CANCEL     = 4'hB;
    localparam logic [3:0]  KEY_PROG       = 4'hC;
    localparam int          MAX_ATTEMPTS   = 3;
    localparam int          BLINK_CYCLES   = 4;
    localparam int          LOCKOUT_CYCLES = 16;
    localparam int          TIMEOUT_CYCLES = 32;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       rdy = 1'b0;
    logic [3:0] keypress = 4'd0;
    logic       locked, ok_led, err_led, lockout, prog_mode, entry_active;
    logic [$clog2(CODE_DIGITS+1)-1:0] digit_count;
    logic [3:0] fail_count;
    logic       timeout_pulse, code_changed;

    always #5 clk = ~clk;

    keylock_controller_n #(
        .CODE_DIGITS(CODE_DIGITS), .RESET_CODE(RESET_CODE),
        .KEY_ENTER(KEY_ENTER), .KEY_CANCEL(KEY_CANCEL), .KEY_PROG(KEY_PROG),
        .MAX_ATTEMPTS(MAX_ATTEMPTS), .BLINK_CYCLES(BLINK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_dut (
        .clk(clk), .resetN(resetN), .rdy(rdy), .keypress(keypress),
        .locked(locked), .ok_led(ok_led), .err_led(err_led), .lockout(lockout),
        .prog_mode(prog_mode), .entry_active(entry_active),
        .digit_count(digit_count), .fail_count(fail_count),
        .timeout_pulse(timeout_pulse), .code_changed(code_changed)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: modes as names, entered digits kept as an unbounded list
    string m_mode;
    bit    m_locked, m_tpulse, m_cchg;
    int    m_fail, m_remain, m_idle;
    int    m_code[$];
    int    m_entry[$];
    int    m_pending[$];

    function automatic bit mdl_in_entry();
        return (m_mode == "ENTRY") || (m_mode == "PROG_OLD") ||
               (m_mode == "PROG_NEW") || (m_mode == "PROG_CONFIRM");
    endfunction

    function automatic bit entry_is_code();
        if (m_entry.size() != m_code.size()) return 1'b0;
        foreach (m_entry[i]) if (m_entry[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit entry_is_pending();
        if (m_entry.size() != CODE_DIGITS || m_entry.size() != m_pending.size()) return 1'b0;
        foreach (m_entry[i]) if (m_entry[i] != m_pending[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic mdl_reset();
        m_mode = "IDLE"; m_locked = 0; m_fail = 0; m_remain = 0; m_idle = 0;
        m_tpulse = 0; m_cchg = 0;
        m_entry.delete(); m_pending.delete(); m_code.delete();
        for (int i = CODE_DIGITS - 1; i >= 0; i--)
            m_code.push_back(int'((RESET_CODE >> (4 * i)) & 32'hF));
    endtask

    task automatic mdl_to_idle();
        m_mode = "IDLE"; m_entry.delete(); m_pending.delete();
    endtask

    task automatic mdl_hold(input string md);
        m_mode = md;
        m_remain = (md == "LOCKOUT") ? LOCKOUT_CYCLES : BLINK_CYCLES;
        m_entry.delete(); m_pending.delete();
    endtask

    task automatic mdl_fail();
        m_fail = (m_fail >= 15) ? 15 : m_fail + 1;
        if (m_fail == MAX_ATTEMPTS) mdl_hold("LOCKOUT");
        else                        mdl_hold("ERROR");
    endtask

    task automatic mdl_step(input logic r, input logic [3:0] k);
        bit dig;
        dig = r && (k <= 4'd9);
        m_tpulse = 0; m_cchg = 0;
        if (m_mode == "OK" || m_mode == "ERROR" || m_mode == "LOCKOUT") begin
            m_remain--;
            if (m_remain == 0) begin
                if (m_mode == "LOCKOUT") m_fail = 0;
                mdl_to_idle();
            end
        end else if (m_mode == "IDLE") begin
            if (dig) begin
                m_mode = "ENTRY"; m_entry.delete(); m_entry.push_back(int'(k)); m_idle = 0;
            end else if (r && k == KEY_PROG) begin
                m_mode = "PROG_OLD"; m_entry.delete(); m_idle = 0;
            end
        end else if (!r) begin
            m_idle++;
            if (m_idle == TIMEOUT_CYCLES) begin mdl_to_idle(); m_tpulse = 1; end
        end else begin
            m_idle = 0;
            if (dig) m_entry.push_back(int'(k));
            else if (k == KEY_CANCEL) mdl_to_idle();
            else if (m_mode == "ENTRY" && k == KEY_ENTER) begin
                if (entry_is_code()) begin m_locked = !m_locked; m_fail = 0; mdl_hold("OK"); end
                else mdl_fail();
            end else if (m_mode != "ENTRY" && k == KEY_PROG) begin
                if (m_mode == "PROG_OLD") begin
                    if (entry_is_code()) begin m_mode = "PROG_NEW"; m_entry.delete(); m_fail = 0; end
                    else mdl_fail();
                end else if (m_mode == "PROG_NEW") begin
                    if (m_entry.size() == CODE_DIGITS) begin
                        m_pending = m_entry; m_entry.delete(); m_mode = "PROG_CONFIRM";
                    end else mdl_hold("ERROR");
                end else begin
                    if (entry_is_pending()) begin
                        m_code = m_pending; m_cchg = 1; mdl_hold("OK");
                    end else mdl_hold("ERROR");
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        int dc;
        dc = 0;
        if (mdl_in_entry()) dc = (m_entry.size() > CODE_DIGITS) ? CODE_DIGITS : m_entry.size();
        chk("locked", 32'(locked), 32'(m_locked));
        chk("ok_led", 32'(ok_led), 32'(m_mode == "OK"));
        chk("err_led", 32'(err_led), 32'(m_mode == "ERROR"));
        chk("lockout", 32'(lockout), 32'(m_mode == "LOCKOUT"));
        chk("prog_mode", 32'(prog_mode), 32'(mdl_in_entry() && m_mode != "ENTRY"));
        chk("entry_active", 32'(entry_active), 32'(mdl_in_entry()));
        chk("digit_count", 32'(digit_count), 32'(dc));
        chk("fail_count", 32'(fail_count), 32'(m_fail));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_tpulse));
        chk("code_changed", 32'(code_changed), 32'(m_cchg));
    endtask

    task automatic cycle(input logic r, input logic [3:0] k);
        rdy = r; keypress = k;
        @(posedge clk);
        mdl_step(r, k);
        #1;
        check_all();
    endtask

    task automatic key(input logic [3:0] k);
        cycle(1'b1, k);
        cycle(1'b0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 4'd0);
    endtask

    task automatic rkey(input logic [3:0] k);
        cycle(1'b1, k);
        if ($urandom_range(0, 1) == 1) cycle(1'b0, 4'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        resetN = 1'b0; rdy = 1'b0; keypress = 4'd0;
        mdl_reset();
        #1;
        check_all();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    function automatic logic [3:0] pick_cmd();
        int s;
        s = int'($urandom_range(0, 3));
        return (s == 0) ? KEY_CANCEL : ((s == 1) ? KEY_PROG : KEY_ENTER);
    endfunction

    initial begin
        int snap[$];
        int n;
        int sel;

        resetN = 1'b0;
        mdl_reset();
        #3;
        check_all();
        @(negedge clk);
        resetN = 1'b1;

        // Lock then unlock with the reset code
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        chk("unlock_locked", 32'(locked), 32'd1);
        chk("unlock_ok_first", 32'(ok_led), 32'd1);
        idle(3);
        chk("unlock_ok_last", 32'(ok_led), 32'd1);
        idle(1);
        chk("unlock_ok_done", 32'(ok_led), 32'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        chk("relock_locked", 32'(locked), 32'd0);
        idle(5);

        // Three wrong codes lead to lockout; keys ignored during it
        for (int a = 1; a <= 3; a++) begin
            key(4'd1); key(4'd2); key(4'd3); key(4'd5);
            cycle(1'b1, KEY_ENTER);
            chk("wrong_fail_count", 32'(fail_count), 32'(a));
            if (a < 3) begin
                chk("wrong_err_led", 32'(err_led), 32'd1);
                idle(5);
            end
        end
        chk("lockout_on", 32'(lockout), 32'd1);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        idle(6);
        chk("lockout_last", 32'(lockout), 32'd1);
        idle(1);
        chk("lockout_off", 32'(lockout), 32'd0);
        chk("lockout_fail_clr", 32'(fail_count), 32'd0);
        chk("lockout_locked", 32'(locked), 32'd0);

        // Overflow and short entries
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        cycle(1'b1, KEY_ENTER);
        chk("ovf_err", 32'(err_led), 32'd1);
        chk("ovf_fail", 32'(fail_count), 32'd1);
        idle(5);
        key(4'd1); key(4'd2);
        cycle(1'b1, KEY_ENTER);
        chk("short_fail", 32'(fail_count), 32'd2);
        idle(5);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        idle(5);

        // Reprogram to 9876
        key(KEY_PROG); key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        key(KEY_PROG); key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        key(KEY_PROG); key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        cycle(1'b1, KEY_PROG);
        chk("prog_changed", 32'(code_changed), 32'd1);
        chk("prog_ok", 32'(ok_led), 32'd1);
        cycle(1'b0, 4'd0);
        chk("prog_changed_pulse", 32'(code_changed), 32'd0);
        idle(4);
        key(4'd9); key(4'd8); key(4'd7); key(4'd6);
        cycle(1'b1, KEY_ENTER);
        chk("newcode_ok", 32'(ok_led), 32'd1);
        idle(5);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        chk("oldcode_err", 32'(err_led), 32'd1);
        idle(5);

        // Reset mid-entry restores the reset code
        key(4'd1);
        mid_reset();
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_dcnt", 32'(digit_count), 32'd0);

        // Confirm mismatch: no penalty, code unchanged
        key(KEY_PROG); key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        key(KEY_PROG); key(4'd5); key(4'd5); key(4'd5); key(4'd5);
        key(KEY_PROG); key(4'd5); key(4'd5); key(4'd5); key(4'd6);
        cycle(1'b1, KEY_PROG);
        chk("confirm_err", 32'(err_led), 32'd1);
        chk("confirm_fail", 32'(fail_count), 32'd0);
        idle(5);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        cycle(1'b1, KEY_ENTER);
        chk("confirm_keep_ok", 32'(ok_led), 32'd1);
        idle(5);

        // Timeout after exactly TIMEOUT_CYCLES idle cycles
        cycle(1'b1, 4'd1); cycle(1'b1, 4'd2);
        idle(TIMEOUT_CYCLES - 1);
        chk("tmo_still_entry", 32'(entry_active), 32'd1);
        cycle(1'b0, 4'd0);
        chk("tmo_pulse", 32'(timeout_pulse), 32'd1);
        chk("tmo_idle", 32'(entry_active), 32'd0);
        chk("tmo_dcnt", 32'(digit_count), 32'd0);
        cycle(1'b0, 4'd0);
        chk("tmo_pulse_end", 32'(timeout_pulse), 32'd0);

        // Key on the expiry cycle wins
        cycle(1'b1, 4'd1); cycle(1'b1, 4'd2);
        idle(TIMEOUT_CYCLES - 1);
        cycle(1'b1, 4'd3);
        chk("expiry_key_entry", 32'(entry_active), 32'd1);
        chk("expiry_key_dcnt", 32'(digit_count), 32'd3);
        chk("expiry_key_nopulse", 32'(timeout_pulse), 32'd0);
        key(KEY_CANCEL);

        // Random key traffic against the model
        for (int it = 0; it < 200; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3) begin
                snap = m_code;
                foreach (snap[i]) rkey(4'(snap[i]));
                rkey(pick_cmd());
            end else if (sel < 8) begin
                n = int'($urandom_range(1, 6));
                for (int j = 0; j < n; j++) rkey(4'($urandom_range(0, 15)));
            end else begin
                idle(int'($urandom_range(20, 40)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
